// File: rtl/ifu_iccm_banked_arb.sv
// ICCM bank array with an aligned multi-word fetch read port and a single-word write port.
// Bank conflicts favour the fetch until the write has been denied STARVE_MAX cycles in a row.
module ifu_iccm_banked_arb #(
  parameter int WADDR_W     = 14,
  parameter int WORD_W      = 39,
  parameter int NUM_BANKS   = 4,
  parameter int FETCH_WORDS = 4,
  parameter int RD_LAT      = 1,
  parameter int STARVE_MAX  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_valid,
  input  logic [WADDR_W-1:0]            rd_waddr,
  output logic                          rd_ready,
  output logic                          rd_rsp_valid,
  output logic [FETCH_WORDS*WORD_W-1:0] rd_rsp_data,
  input  logic                          wr_valid,
  input  logic [WADDR_W-1:0]            wr_waddr,
  input  logic [WORD_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic [15:0]                   conflict_cnt
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int IDX_W  = WADDR_W - BANK_W;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int GRP_W  = FETCH_WORDS * WORD_W;
  localparam int SC_W   = $clog2(STARVE_MAX + 2);
  localparam logic [BANK_W-1:0] GRP_MASK   = ~BANK_W'(FETCH_WORDS - 1);
  localparam logic [SC_W-1:0]   STARVE_LIM = SC_W'(STARVE_MAX);
  localparam bit PARAM_OK = (NUM_BANKS >= 2) && ((NUM_BANKS & (NUM_BANKS - 1)) == 0) &&
                            (FETCH_WORDS >= 1) && ((FETCH_WORDS & (FETCH_WORDS - 1)) == 0) &&
                            (FETCH_WORDS <= NUM_BANKS) && (RD_LAT == 1 || RD_LAT == 2) &&
                            (STARVE_MAX >= 0);

  // Valid/ready: a request transfers in every cycle where valid && ready. Both readies are
  // combinational from the two ports' valids and addresses, so a master must never wait for
  // ready before raising valid.
  logic [BANK_W-1:0] rd_grp_bank;
  logic [BANK_W-1:0] wr_bank;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              conflict;
  logic              write_wins;
  logic              rd_grant;
  logic              wr_grant;
  logic [SC_W-1:0]   starve_cnt;
  logic [WORD_W-1:0] bank_rd [NUM_BANKS];
  logic [GRP_W-1:0]  rd_group;
  logic              s1_valid;
  logic [GRP_W-1:0]  s1_data;

  // An aligned group never wraps past a bank-row boundary, so every word shares rd_idx.
  assign rd_grp_bank = rd_waddr[BANK_W-1:0] & GRP_MASK;
  assign rd_idx      = rd_waddr[WADDR_W-1:BANK_W];
  assign wr_bank     = wr_waddr[BANK_W-1:0];
  assign wr_idx      = wr_waddr[WADDR_W-1:BANK_W];

  assign conflict   = rd_valid & wr_valid & ((wr_bank & GRP_MASK) == rd_grp_bank);
  assign write_wins = (starve_cnt == STARVE_LIM);
  assign rd_ready   = ~conflict | ~write_wins;
  assign wr_ready   = ~conflict | write_wins;
  assign rd_grant   = rd_valid & rd_ready;
  assign wr_grant   = wr_valid & wr_ready;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WORD_W-1:0] ram [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_grant && (wr_bank == BANK_W'(b))) ram[wr_idx] <= wr_data;
    end
    assign bank_rd[b] = ram[rd_idx];
  end

  // Rotate so group word k lands in slice k whatever bank the group starts in.
  always_comb begin
    rd_group = '0;
    for (int k = 0; k < FETCH_WORDS; k++) begin
      rd_group[k*WORD_W +: WORD_W] = bank_rd[rd_grp_bank + BANK_W'(k)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_grant;
      if (rd_grant) s1_data <= rd_group;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (wr_grant) starve_cnt <= '0;
      else if (wr_valid && (starve_cnt != STARVE_LIM)) starve_cnt <= starve_cnt + 1'b1;
      if (conflict && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic             s2_valid;
    logic [GRP_W-1:0] s2_data;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end
    assign rd_rsp_valid = s2_valid;
    assign rd_rsp_data  = s2_data;
  end else begin : g_lat1
    assign rd_rsp_valid = s1_valid;
    assign rd_rsp_data  = s1_data;
  end

  param_legal: assert property (@(posedge clk) PARAM_OK);
  rsp_known:   assert property (@(posedge clk) disable iff (rst)
                                rd_rsp_valid |-> !$isunknown(rd_rsp_data));
endmodule

// File: tb/tb_ifu_iccm_banked_arb.sv
// Bench for ifu_iccm_banked_arb: one 4-word RD_LAT=1 instance and one 2-word RD_LAT=2 instance,
// both tracked by a word-level memory model with a grant-time response queue.
module tb_ifu_iccm_banked_arb;
  localparam int WA  = 14;
  localparam int WBA = 8;
  localparam int WW  = 39;
  localparam int NB  = 4;
  localparam int FWA = 4;
  localparam int FWB = 2;
  localparam int LATA = 1;
  localparam int LATB = 2;
  localparam int SM  = 3;
  localparam int DA  = FWA * WW;
  localparam int DB  = FWB * WW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           rd_valid_a, rd_ready_a, rsp_valid_a, wr_valid_a, wr_ready_a;
  logic [WA-1:0]  rd_waddr_a, wr_waddr_a;
  logic [DA-1:0]  rsp_data_a;
  logic [WW-1:0]  wr_data_a;
  logic [15:0]    ccnt_a;
  logic           rd_valid_b, rd_ready_b, rsp_valid_b, wr_valid_b, wr_ready_b;
  logic [WBA-1:0] rd_waddr_b, wr_waddr_b;
  logic [DB-1:0]  rsp_data_b;
  logic [WW-1:0]  wr_data_b;
  logic [15:0]    ccnt_b;

  ifu_iccm_banked_arb #(.WADDR_W(WA), .WORD_W(WW), .NUM_BANKS(NB), .FETCH_WORDS(FWA),
                        .RD_LAT(LATA), .STARVE_MAX(SM)) dut_a (
    .clk(clk), .rst(rst), .rd_valid(rd_valid_a), .rd_waddr(rd_waddr_a), .rd_ready(rd_ready_a),
    .rd_rsp_valid(rsp_valid_a), .rd_rsp_data(rsp_data_a), .wr_valid(wr_valid_a),
    .wr_waddr(wr_waddr_a), .wr_data(wr_data_a), .wr_ready(wr_ready_a), .conflict_cnt(ccnt_a));

  ifu_iccm_banked_arb #(.WADDR_W(WBA), .WORD_W(WW), .NUM_BANKS(NB), .FETCH_WORDS(FWB),
                        .RD_LAT(LATB), .STARVE_MAX(SM)) dut_b (
    .clk(clk), .rst(rst), .rd_valid(rd_valid_b), .rd_waddr(rd_waddr_b), .rd_ready(rd_ready_b),
    .rd_rsp_valid(rsp_valid_b), .rd_rsp_data(rsp_data_b), .wr_valid(wr_valid_b),
    .wr_waddr(wr_waddr_b), .wr_data(wr_data_b), .wr_ready(wr_ready_b), .conflict_cnt(ccnt_b));

  int n_pass, n_total, cyc;

  // Reference model state: words by address, starvation/conflict counters, responses in flight.
  logic [WW-1:0] mem_a [int];
  logic [WW-1:0] mem_b [int];
  int            starve_a, starve_b, mcnt_a, mcnt_b;
  logic [DA-1:0] exp_q_a [$];
  logic [DB-1:0] exp_q_b [$];
  int            due_q_a [$];
  int            due_q_b [$];
  logic [DA-1:0] last_a;
  logic [DB-1:0] last_b;
  logic          conf_a, conf_b, exp_rr_a, exp_rr_b, exp_wr_a, exp_wr_b, exp_rv_a, exp_rv_b;

  function automatic bit in_set(int rd, int wr, int fw);
    int base;
    base = rd & ~(fw - 1);
    for (int k = 0; k < fw; k++) if (((base + k) % NB) == (wr % NB)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_idle();
    rd_valid_a = 1'b0; rd_waddr_a = '0; wr_valid_a = 1'b0; wr_waddr_a = '0; wr_data_a = '0;
    rd_valid_b = 1'b0; rd_waddr_b = '0; wr_valid_b = 1'b0; wr_waddr_b = '0; wr_data_b = '0;
  endtask

  task automatic clear_models();
    starve_a = 0; starve_b = 0; mcnt_a = 0; mcnt_b = 0;
    exp_q_a.delete(); exp_q_b.delete(); due_q_a.delete(); due_q_b.delete();
    last_a = '0; last_b = '0; exp_rv_a = 1'b0; exp_rv_b = 1'b0;
  endtask

  task automatic predict();
    #2;
    conf_a   = rd_valid_a && wr_valid_a && in_set(int'(rd_waddr_a), int'(wr_waddr_a), FWA);
    exp_rr_a = !conf_a || (starve_a < SM);
    exp_wr_a = !conf_a || (starve_a == SM);
    conf_b   = rd_valid_b && wr_valid_b && in_set(int'(rd_waddr_b), int'(wr_waddr_b), FWB);
    exp_rr_b = !conf_b || (starve_b < SM);
    exp_wr_b = !conf_b || (starve_b == SM);
  endtask

  task automatic advance();
    logic [DA-1:0] ga;
    logic [DB-1:0] gb;
    int base;
    if (rd_valid_a && exp_rr_a) begin
      base = int'(rd_waddr_a) & ~(FWA - 1);
      ga = '0;
      for (int k = 0; k < FWA; k++) ga[k*WW +: WW] = mem_a[base + k];
      exp_q_a.push_back(ga);
      due_q_a.push_back(cyc + LATA);
    end
    if (wr_valid_a && exp_wr_a) begin
      mem_a[int'(wr_waddr_a)] = wr_data_a;
      starve_a = 0;
    end else if (wr_valid_a && starve_a < SM) starve_a++;
    if (conf_a && mcnt_a < 65535) mcnt_a++;
    if (rd_valid_b && exp_rr_b) begin
      base = int'(rd_waddr_b) & ~(FWB - 1);
      gb = '0;
      for (int k = 0; k < FWB; k++) gb[k*WW +: WW] = mem_b[base + k];
      exp_q_b.push_back(gb);
      due_q_b.push_back(cyc + LATB);
    end
    if (wr_valid_b && exp_wr_b) begin
      mem_b[int'(wr_waddr_b)] = wr_data_b;
      starve_b = 0;
    end else if (wr_valid_b && starve_b < SM) starve_b++;
    if (conf_b && mcnt_b < 65535) mcnt_b++;
    @(posedge clk);
    cyc++;
    #1;
    exp_rv_a = 1'b0;
    if (due_q_a.size() > 0 && due_q_a[0] == cyc) begin
      exp_rv_a = 1'b1;
      last_a = exp_q_a.pop_front();
      due_q_a.delete(0);
    end
    exp_rv_b = 1'b0;
    if (due_q_b.size() > 0 && due_q_b[0] == cyc) begin
      exp_rv_b = 1'b1;
      last_b = exp_q_b.pop_front();
      due_q_b.delete(0);
    end
  endtask

  task automatic tick();
    predict();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    clear_models();
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    clear_models();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (rsp_valid_a !== 1'b0) $display("FAIL reset rsp_valid_a: got %b exp 0", rsp_valid_a); else n_pass++;
    n_total++; if (rsp_data_a !== '0) $display("FAIL reset rsp_data_a: got %h exp 0", rsp_data_a); else n_pass++;
    n_total++; if (ccnt_a !== 16'd0) $display("FAIL reset ccnt_a: got %0d exp 0", ccnt_a); else n_pass++;
    n_total++; if (rsp_valid_b !== 1'b0) $display("FAIL reset rsp_valid_b: got %b exp 0", rsp_valid_b); else n_pass++;
    n_total++; if (rsp_data_b !== '0) $display("FAIL reset rsp_data_b: got %h exp 0", rsp_data_b); else n_pass++;
    n_total++; if (ccnt_b !== 16'd0) $display("FAIL reset ccnt_b: got %0d exp 0", ccnt_b); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_fetch_group();
    logic [DA-1:0] exp_grp;
    logic [WA-1:0] addrs [2];
    exp_grp = {39'd107, 39'd106, 39'd105, 39'd104};
    addrs[0] = WA'(4);
    addrs[1] = WA'(7);
    for (int i = 0; i < 8; i++) begin
      set_idle();
      wr_valid_a = 1'b1; wr_waddr_a = WA'(i); wr_data_a = WW'(100 + i);
      predict();
      n_total++; if (wr_ready_a !== exp_wr_a) $display("FAIL fetch_group wr_ready: got %b exp %b", wr_ready_a, exp_wr_a); else n_pass++;
      advance();
    end
    for (int j = 0; j < 2; j++) begin
      set_idle();
      rd_valid_a = 1'b1; rd_waddr_a = addrs[j];
      predict();
      n_total++; if (rd_ready_a !== exp_rr_a) $display("FAIL fetch_group rd_ready: got %b exp %b", rd_ready_a, exp_rr_a); else n_pass++;
      advance();
      set_idle();
      n_total++; if (rsp_valid_a !== exp_rv_a) $display("FAIL fetch_group rsp_valid: got %b exp %b", rsp_valid_a, exp_rv_a); else n_pass++;
      n_total++; if (rsp_data_a !== exp_grp) $display("FAIL fetch_group rsp_data: got %h exp %h", rsp_data_a, exp_grp); else n_pass++;
      tick();
      n_total++; if (rsp_valid_a !== exp_rv_a) $display("FAIL fetch_group idle rsp_valid: got %b exp %b", rsp_valid_a, exp_rv_a); else n_pass++;
      n_total++; if (rsp_data_a !== last_a) $display("FAIL fetch_group hold rsp_data: got %h exp %h", rsp_data_a, last_a); else n_pass++;
    end
  endtask

  task automatic test_conflict();
    for (int i = 0; i < 16; i++) begin
      set_idle();
      wr_valid_b = 1'b1; wr_waddr_b = WBA'(i); wr_data_b = WW'(200 + i);
      tick();
    end
    set_idle();
    rd_valid_b = 1'b1; rd_waddr_b = WBA'(0);
    wr_valid_b = 1'b1; wr_waddr_b = WBA'(9); wr_data_b = WW'(39'h55);
    predict();
    n_total++; if (rd_ready_b !== exp_rr_b) $display("FAIL conflict rd_ready: got %b exp %b", rd_ready_b, exp_rr_b); else n_pass++;
    n_total++; if (wr_ready_b !== exp_wr_b) $display("FAIL conflict wr_ready: got %b exp %b", wr_ready_b, exp_wr_b); else n_pass++;
    advance();
    n_total++; if (ccnt_b !== 16'(mcnt_b)) $display("FAIL conflict ccnt: got %0d exp %0d", ccnt_b, mcnt_b); else n_pass++;
    wr_waddr_b = WBA'(6);
    predict();
    n_total++; if (rd_ready_b !== exp_rr_b) $display("FAIL no_conflict rd_ready: got %b exp %b", rd_ready_b, exp_rr_b); else n_pass++;
    n_total++; if (wr_ready_b !== exp_wr_b) $display("FAIL no_conflict wr_ready: got %b exp %b", wr_ready_b, exp_wr_b); else n_pass++;
    advance();
    n_total++; if (ccnt_b !== 16'(mcnt_b)) $display("FAIL no_conflict ccnt: got %0d exp %0d", ccnt_b, mcnt_b); else n_pass++;
    set_idle();
    repeat (3) tick();
  endtask

  task automatic test_starvation();
    do_reset();
    rd_valid_a = 1'b1; rd_waddr_a = WA'(0);
    wr_valid_a = 1'b1; wr_waddr_a = WA'(1); wr_data_a = WW'(39'h70_0000_0001);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) wr_valid_a = 1'b0;
      predict();
      n_total++; if (rd_ready_a !== exp_rr_a) $display("FAIL starve rd_ready cyc%0d: got %b exp %b", i, rd_ready_a, exp_rr_a); else n_pass++;
      n_total++; if (wr_ready_a !== exp_wr_a) $display("FAIL starve wr_ready cyc%0d: got %b exp %b", i, wr_ready_a, exp_wr_a); else n_pass++;
      advance();
      n_total++; if (rsp_valid_a !== exp_rv_a) $display("FAIL starve rsp_valid cyc%0d: got %b exp %b", i, rsp_valid_a, exp_rv_a); else n_pass++;
      n_total++; if (rsp_data_a !== last_a) $display("FAIL starve rsp_data cyc%0d: got %h exp %h", i, rsp_data_a, last_a); else n_pass++;
    end
    n_total++; if (ccnt_a !== 16'(mcnt_a)) $display("FAIL starve ccnt: got %0d exp %0d", ccnt_a, mcnt_a); else n_pass++;
    set_idle();
    tick();
  endtask

  task automatic test_write_forward();
    set_idle();
    wr_valid_a = 1'b1; wr_waddr_a = WA'(2); wr_data_a = WW'(39'h1234);
    tick();
    set_idle();
    rd_valid_a = 1'b1; rd_waddr_a = WA'(0);
    tick();
    set_idle();
    n_total++; if (rsp_valid_a !== exp_rv_a) $display("FAIL write_forward rsp_valid: got %b exp %b", rsp_valid_a, exp_rv_a); else n_pass++;
    n_total++; if (rsp_data_a[2*WW +: WW] !== 39'h1234) $display("FAIL write_forward slice2: got %h exp %h", rsp_data_a[2*WW +: WW], 39'h1234); else n_pass++;
    n_total++; if (rsp_data_a !== last_a) $display("FAIL write_forward rsp_data: got %h exp %h", rsp_data_a, last_a); else n_pass++;
  endtask

  task automatic test_rd_lat2();
    set_idle();
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      if (i < 3) begin
        rd_valid_b = 1'b1; rd_waddr_b = WBA'(2 * i);
      end
      tick();
      n_total++; if (rsp_valid_b !== ((i >= 1) && (i <= 3))) $display("FAIL rd_lat2 timing cyc%0d: got %b exp %b", i, rsp_valid_b, ((i >= 1) && (i <= 3))); else n_pass++;
      n_total++; if (rsp_valid_b !== exp_rv_b) $display("FAIL rd_lat2 rsp_valid cyc%0d: got %b exp %b", i, rsp_valid_b, exp_rv_b); else n_pass++;
      n_total++; if (rsp_data_b !== last_b) $display("FAIL rd_lat2 rsp_data cyc%0d: got %h exp %h", i, rsp_data_b, last_b); else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    set_idle();
    rd_valid_b = 1'b1; rd_waddr_b = WBA'(0);
    wr_valid_b = 1'b1; wr_waddr_b = WBA'(1); wr_data_b = WW'(39'h2aa);
    tick();
    set_idle();
    rst = 1'b1;
    clear_models();
    #1;
    n_total++; if (ccnt_b !== 16'd0) $display("FAIL midreset ccnt_b: got %0d exp 0", ccnt_b); else n_pass++;
    n_total++; if (rsp_valid_b !== 1'b0) $display("FAIL midreset rsp_valid_b: got %b exp 0", rsp_valid_b); else n_pass++;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (rsp_valid_b !== 1'b0) $display("FAIL midreset dropped rsp cyc%0d: got %b exp 0", i, rsp_valid_b); else n_pass++;
      n_total++; if (rsp_data_b !== last_b) $display("FAIL midreset rsp_data cyc%0d: got %h exp %h", i, rsp_data_b, last_b); else n_pass++;
      n_total++; if (ccnt_b !== 16'(mcnt_b)) $display("FAIL midreset ccnt cyc%0d: got %0d exp %0d", i, ccnt_b, mcnt_b); else n_pass++;
    end
    n_total++; if (ccnt_a !== 16'd0) $display("FAIL midreset ccnt_a: got %0d exp 0", ccnt_a); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 64; i++) begin
      set_idle();
      wr_valid_a = 1'b1; wr_waddr_a = WA'(i); wr_data_a = WW'({$urandom(), $urandom()});
      wr_valid_b = 1'b1; wr_waddr_b = WBA'(i); wr_data_b = WW'({$urandom(), $urandom()});
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      rd_valid_a = 1'($urandom_range(0, 1)); rd_waddr_a = WA'($urandom_range(0, 63));
      wr_valid_a = 1'($urandom_range(0, 1)); wr_waddr_a = WA'($urandom_range(0, 63));
      wr_data_a  = WW'({$urandom(), $urandom()});
      rd_valid_b = 1'($urandom_range(0, 1)); rd_waddr_b = WBA'($urandom_range(0, 63));
      wr_valid_b = 1'($urandom_range(0, 1)); wr_waddr_b = WBA'($urandom_range(0, 63));
      wr_data_b  = WW'({$urandom(), $urandom()});
      predict();
      n_total++; if (rd_ready_a !== exp_rr_a) $display("FAIL random rd_ready_a it%0d: got %b exp %b", i, rd_ready_a, exp_rr_a); else n_pass++;
      n_total++; if (wr_ready_a !== exp_wr_a) $display("FAIL random wr_ready_a it%0d: got %b exp %b", i, wr_ready_a, exp_wr_a); else n_pass++;
      n_total++; if (rd_ready_b !== exp_rr_b) $display("FAIL random rd_ready_b it%0d: got %b exp %b", i, rd_ready_b, exp_rr_b); else n_pass++;
      n_total++; if (wr_ready_b !== exp_wr_b) $display("FAIL random wr_ready_b it%0d: got %b exp %b", i, wr_ready_b, exp_wr_b); else n_pass++;
      advance();
      n_total++; if (rsp_valid_a !== exp_rv_a) $display("FAIL random rsp_valid_a it%0d: got %b exp %b", i, rsp_valid_a, exp_rv_a); else n_pass++;
      n_total++; if (rsp_data_a !== last_a) $display("FAIL random rsp_data_a it%0d: got %h exp %h", i, rsp_data_a, last_a); else n_pass++;
      n_total++; if (ccnt_a !== 16'(mcnt_a)) $display("FAIL random ccnt_a it%0d: got %0d exp %0d", i, ccnt_a, mcnt_a); else n_pass++;
      n_total++; if (rsp_valid_b !== exp_rv_b) $display("FAIL random rsp_valid_b it%0d: got %b exp %b", i, rsp_valid_b, exp_rv_b); else n_pass++;
      n_total++; if (rsp_data_b !== last_b) $display("FAIL random rsp_data_b it%0d: got %h exp %h", i, rsp_data_b, last_b); else n_pass++;
      n_total++; if (ccnt_b !== 16'(mcnt_b)) $display("FAIL random ccnt_b it%0d: got %0d exp %0d", i, ccnt_b, mcnt_b); else n_pass++;
    end
    set_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp bench completion");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    cyc = 0;
    test_reset();
    test_fetch_group();
    test_conflict();
    test_starvation();
    test_write_forward();
    test_rd_lat2();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
